method_mul_responder: RTL and testbench

- Callee side of the method-call handshake (req/busy/return) that generated modules expose and sim benches drive as callers.
- Implements one method, mul(a, b), as an iterative shift-add multiplier. Returns the low WIDTH bits of a*b.
- Used as a synthesizable responder in method-call benches, and as a drop-in callee behind generated callers.

---
 rtl/method_call_pkg.sv | 13 +
 rtl/method_call_ctrl.sv | 54 +++++
 rtl/method_mul_responder.sv | 68 ++++++
 tb/tb_method_mul_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/method_call_pkg.sv
// Shared definitions for single-method callee responders (req/busy/return handshake).
package method_call_pkg;

    // Handshake controller state: one bit, idle or executing a call.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } call_state_t;

    // Default operand/return width for responders of this protocol.
    localparam int DEFAULT_WIDTH = 32;

endpackage : method_call_pkg

// File: rtl/method_call_ctrl.sv
// Generic method-call handshake FSM: accepts a request when idle, stays busy
// until the datapath reports done, then returns to idle for at least one cycle.
module method_call_ctrl
    import method_call_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic done,
    output logic start,
    output logic busy
);

    call_state_t state_r;

    // Acceptance strobe: a request seen while idle starts a call this cycle.
    always_comb begin
        start = 1'b0;
        if (state_r == ST_IDLE) begin
            start = req;
        end else begin
            start = 1'b0;
        end
    end

    // Handshake state register; reset aborts any call in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Busy is a direct decode of the state flop, so it is glitch-free and registered.
    assign busy = (state_r == ST_CALC);

endmodule : method_call_ctrl

// File: rtl/method_mul_responder.sv
// Callee for mul(a, b): iterative shift-add multiplier returning the low
// WIDTH bits of a*b. Terminates early once the remaining multiplier is zero.
module method_mul_responder
    import method_call_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul_req,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             mul_busy,
    output logic [WIDTH-1:0] mul_return
);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] return_r;
    logic             start_s;
    logic             busy_s;
    logic             done_s;

    // Completion one cycle after the last add: nothing left to shift in.
    assign done_s = (mplier_r == {WIDTH{1'b0}});

    method_call_ctrl u_ctrl (
        .clk   (clk),
        .reset (reset),
        .req   (mul_req),
        .done  (done_s),
        .start (start_s),
        .busy  (busy_s)
    );

    // Datapath: latch arguments on acceptance, then one add/shift step per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            return_r <= {WIDTH{1'b0}};
        end else if (start_s) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= mul_a;
            mplier_r <= mul_b;
        end else if (busy_s) begin
            if (!done_s) begin
                if (mplier_r[0]) begin
                    acc_r <= acc_r + mcand_r;
                end else begin
                    acc_r <= acc_r;
                end
                mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            end else begin
                return_r <= acc_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign mul_busy   = busy_s;
    assign mul_return = return_r;

endmodule : method_mul_responder

// File: tb/tb_method_mul_responder.sv
// Self-checking bench for method_mul_responder: a countdown-based call model
// is compared with the DUT every cycle, plus literal expectations per call.
module tb_method_mul_responder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mul_req;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_busy;
    logic [W-1:0] mul_return;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    method_mul_responder #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mul_req    (mul_req),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_busy   (mul_busy),
        .mul_return (mul_return)
    );

    // Busy duration of a call: (index of MSB of b, plus 1) + 1; b=0 gives 1.
    function automatic int lat(logic [W-1:0] b);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) k = i + 1;
        end
        return k + 1;
    endfunction

    function automatic logic [W-1:0] prod(logic [W-1:0] a, logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a call is a countdown of lat(b) busy cycles, then the product appears.
    logic         m_busy;
    logic [W-1:0] m_ret;
    logic [W-1:0] m_pend;
    int           m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_ret  <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (mul_req) begin
                m_busy <= 1'b1;
                m_left <= lat(mul_b);
                m_pend <= prod(mul_a, mul_b);
            end
        end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_ret  <= m_pend;
            m_left <= 0;
        end else begin
            m_left <= m_left - 1;
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {63'd0, mul_busy}, {63'd0, m_busy});
            check("model_return", {32'd0, mul_return}, {32'd0, m_ret});
        end
    end

    // One-cycle request pulse, then measure busy length and final return.
    task automatic run_call(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_ret, input int exp_busy, input string name);
        int cnt;
        @(negedge clk);
        mul_a   = a;
        mul_b   = b;
        mul_req = 1'b1;
        @(negedge clk);
        mul_req = 1'b0;
        cnt = 0;
        while (mul_busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
        check({name, "_return"}, {32'd0, mul_return}, {32'd0, exp_ret});
    endtask

    initial begin
        int cnt;
        logic [W-1:0] cont_exp [4];
        cont_exp[0] = 32'd15;
        cont_exp[1] = 32'd15;
        cont_exp[2] = 32'd20;
        cont_exp[3] = 32'd20;

        reset   = 1'b1;
        mul_req = 1'b0;
        mul_a   = '0;
        mul_b   = '0;
        repeat (6) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", {63'd0, mul_busy}, 64'd0);
        check("reset_return", {32'd0, mul_return}, 64'd0);
        repeat (50) @(negedge clk);
        check("idle_busy", {63'd0, mul_busy}, 64'd0);
        check("idle_return", {32'd0, mul_return}, 64'd0);

        run_call(32'd100, 32'd200, 32'd20000, 9, "basic");
        repeat (5) @(negedge clk);
        check("basic_hold", {32'd0, mul_return}, 64'd20000);
        run_call(32'd12345, 32'd0, 32'd0, 1, "b_zero");
        run_call(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "max");
        run_call(32'd7, 32'd1, 32'd7, 2, "b_one");

        // Continuous request: 4 busy, 1 idle, repeating; a change mid-call applies next call.
        @(negedge clk);
        mul_a   = 32'd3;
        mul_b   = 32'd5;
        mul_req = 1'b1;
        for (int rep = 0; rep < 4; rep++) begin
            @(negedge clk);
            cnt = 0;
            while (mul_busy === 1'b1 && cnt < 100) begin
                if (rep == 1 && cnt == 1) mul_a = 32'd4;
                if (rep == 3 && cnt == 1) mul_req = 1'b0;
                cnt++;
                @(negedge clk);
            end
            check("cont_busy_cycles", 64'(cnt), 64'd4);
            check("cont_return", {32'd0, mul_return}, {32'd0, cont_exp[rep]});
        end

        // Reset mid-calculation aborts the call without a return update.
        @(negedge clk);
        mul_a   = 32'd100;
        mul_b   = 32'h8000_0000;
        mul_req = 1'b1;
        @(negedge clk);
        mul_req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'd0, mul_busy}, 64'd0);
        check("abort_return", {32'd0, mul_return}, 64'd0);
        run_call(32'd6, 32'd7, 32'd42, 4, "after_abort");

        // Random arguments and requests every cycle, including churn while busy.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            mul_a   = $urandom;
            mul_b   = $urandom >> $urandom_range(31, 0);
            mul_req = ($urandom_range(1, 0) == 1);
        end
        @(negedge clk);
        mul_req = 1'b0;
        cnt = 0;
        while (mul_busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("random_drain", {63'd0, mul_busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_method_mul_responder
